// File: rtl/dcache_dm_wb_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_dm_wb_pkg;

  localparam int DCACHE_LINE_BYTES = 64;
  localparam int DCACHE_NUM_LINES  = 4;

  localparam logic MEM_ACCESS_READ  = 1'b0;
  localparam logic MEM_ACCESS_WRITE = 1'b1;
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB
  } dcache_state_t;

  // Unknown size codes behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dcache_lane_sel.sv
// Byte-lane steering: load extraction from a line and store merge into a line.
module dcache_lane_sel
  import dcache_dm_wb_pkg::*;
#(
  parameter int LINE_BYTES = DCACHE_LINE_BYTES,
  parameter int DATA_W     = 32,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int LINE_W    = 8 * LINE_BYTES
) (
  input  logic [LINE_W-1:0] line,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        size,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LINE_W-1:0] wline
);

  logic [OFF_W+2:0]  bit_shift;
  logic [DATA_W-1:0] size_mask;
  logic [LINE_W-1:0] lane_mask;
  logic [LINE_W-1:0] lane_data;

  assign bit_shift = {offset, 3'b000};

  always_comb begin
    case (size)
      SIZE_BYTE: size_mask = DATA_W'(32'h0000_00ff);
      SIZE_HALF: size_mask = DATA_W'(32'h0000_ffff);
      default:   size_mask = DATA_W'(32'hffff_ffff);
    endcase
  end

  assign rdata     = DATA_W'(line >> bit_shift) & size_mask;
  assign lane_mask = LINE_W'(size_mask) << bit_shift;
  assign lane_data = LINE_W'(wdata) << bit_shift;
  assign wline     = (line & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide memory
// port and a full flush sequence.
module dcache_dm_wb
  import dcache_dm_wb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = DCACHE_LINE_BYTES,
  parameter int NUM_LINES  = DCACHE_NUM_LINES,
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W    = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic              stall,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wline,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rline
);

  dcache_state_t state, state_nxt;
  logic [IDX_W-1:0]     cnt;
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              hit, misalign;
  logic [DATA_W-1:0] lane_rdata;
  logic [LINE_W-1:0] lane_wline;
  logic              flush_start, cnt_inc, store_hit, refill_done, line_clear;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_off  = req_addr[OFF_W-1:0];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign misalign = is_misaligned(req_size, req_addr[1:0]);

  dcache_lane_sel #(
    .LINE_BYTES(LINE_BYTES),
    .DATA_W    (DATA_W)
  ) u_lane_sel (
    .line  (data_mem[req_idx]),
    .offset(req_off),
    .size  (req_size),
    .wdata (req_wdata),
    .rdata (lane_rdata),
    .wline (lane_wline)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nxt     = state;
    stall         = 1'b0;
    resp_valid    = 1'b0;
    resp_misalign = 1'b0;
    resp_rdata    = '0;
    flush_done    = 1'b0;
    mem_req       = 1'b0;
    mem_rw        = MEM_ACCESS_READ;
    mem_addr      = '0;
    mem_wline     = '0;
    flush_start   = 1'b0;
    cnt_inc       = 1'b0;
    store_hit     = 1'b0;
    refill_done   = 1'b0;
    line_clear    = 1'b0;
    // Outputs are held at zero for the whole reset interval, not just after it.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (flush) begin
            stall       = 1'b1;
            flush_start = 1'b1;
            state_nxt   = FLUSH_SCAN;
          end else if (req_valid) begin
            if (misalign) begin
              resp_valid    = 1'b1;
              resp_misalign = 1'b1;
            end else if (hit) begin
              resp_valid = 1'b1;
              if (req_rw == WR) store_hit  = 1'b1;
              else              resp_rdata = lane_rdata;
            end else begin
              stall     = 1'b1;
              state_nxt = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_rw    = MEM_ACCESS_WRITE;
          mem_addr  = {tag_mem[req_idx], req_idx, {OFF_W{1'b0}}};
          mem_wline = data_mem[req_idx];
          if (mem_ack) state_nxt = REFILL;
        end
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
          if (mem_ack) begin
            refill_done = 1'b1;
            state_nxt   = IDLE;
          end
        end
        FLUSH_SCAN: begin
          stall = 1'b1;
          if (valid[cnt] && dirty[cnt]) begin
            state_nxt = FLUSH_WB;
          end else begin
            line_clear = 1'b1;
            cnt_inc    = 1'b1;
            if (cnt == IDX_W'(NUM_LINES - 1)) begin
              flush_done = 1'b1;
              state_nxt  = IDLE;
            end
          end
        end
        FLUSH_WB: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          mem_rw    = MEM_ACCESS_WRITE;
          mem_addr  = {tag_mem[cnt], cnt, {OFF_W{1'b0}}};
          mem_wline = data_mem[cnt];
          // The scan revisits this now-clean line and advances past it.
          if (mem_ack) begin
            line_clear = 1'b1;
            state_nxt  = FLUSH_SCAN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (flush_start)  cnt <= '0;
      else if (cnt_inc) cnt <= cnt + IDX_W'(1);
      if (store_hit) dirty[req_idx] <= 1'b1;
      if (refill_done) begin
        valid[req_idx] <= 1'b1;
        dirty[req_idx] <= 1'b0;
      end
      if (line_clear) begin
        valid[cnt] <= 1'b0;
        dirty[cnt] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid bits alone
  // decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (store_hit) data_mem[req_idx] <= lane_wline;
    if (refill_done) begin
      data_mem[req_idx] <= mem_rline;
      tag_mem[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Self-checking bench: byte-addressed golden memory plus a line-presence model
// predicts data, latency and memory traffic for every access.
module tb_dcache_dm_wb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LB     = 64;
  localparam int NL     = 4;
  localparam int LINE_W = 8 * LB;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_rw = 1'b0;
  logic [2:0]        req_size = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              flush = 1'b0;
  logic              resp_valid, resp_misalign, stall, flush_done;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_req, mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic              mem_ack = 1'b0;
  logic [LINE_W-1:0] mem_rline = '0;

  always #5 clk = ~clk;

  dcache_dm_wb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .stall(stall), .flush_done(flush_done),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_ack(mem_ack), .mem_rline(mem_rline)
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic mem_hold = 1'b0;

  logic [31:0]       wb_addr_q[$];
  logic [LINE_W-1:0] wb_line_q[$];
  logic [31:0]       rf_addr_q[$];

  logic [7:0] golden  [logic [31:0]];
  logic [7:0] backing [logic [31:0]];

  logic        m_valid [NL];
  logic        m_dirty [NL];
  logic [31:0] m_base  [NL];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3c;
  endfunction

  function automatic logic [7:0] gbyte(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bbyte(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : init_byte(a);
  endfunction

  function automatic logic [LINE_W-1:0] gline(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int b = 0; b < LB; b++) l[8*b +: 8] = gbyte(base + 32'(b));
    return l;
  endfunction

  // Memory responder: acks each request after lat extra cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || mem_hold || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt < lat) begin
        wait_cnt++;
      end else begin
        if (mem_rw) begin
          wb_addr_q.push_back(mem_addr);
          wb_line_q.push_back(mem_wline);
          for (int b = 0; b < LB; b++) backing[mem_addr + 32'(b)] = mem_wline[8*b +: 8];
        end else begin
          rf_addr_q.push_back(mem_addr);
          for (int b = 0; b < LB; b++) mem_rline[8*b +: 8] = bbyte(mem_addr + 32'(b));
        end
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_base[i]  = '0;
    end
    golden.delete();
    foreach (backing[k]) golden[k] = backing[k];
  endtask

  // Starts on a falling edge; returns on a falling edge after the commit edge.
  task automatic access(input logic rw, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                        output logic mreq, output int cyc, output logic ok);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_addr = addr; req_wdata = wd;
    cyc = 0;
    #1;
    while (!resp_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = resp_valid; rd = resp_rdata; mis = resp_misalign; mreq = mem_req;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic model_access(input logic rw, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] base, victim, exp_rd;
    logic exp_mis, exp_hit, exp_wb, mis, mreq, ok;
    int idx, exp_cyc, cyc, nbytes;
    base    = addr & ~32'h3f;
    idx     = int'((addr >> 6) & 32'h3);
    exp_mis = (size == 3'b001 && addr[0]) || (size != 3'b000 && size != 3'b001 && addr[1:0] != 2'b00);
    exp_hit = m_valid[idx] && (m_base[idx] == base);
    exp_wb  = !exp_mis && !exp_hit && m_valid[idx] && m_dirty[idx];
    victim  = m_base[idx];
    exp_cyc = (exp_mis || exp_hit) ? 0 : (exp_wb ? 2 * lat + 3 : lat + 2);
    nbytes  = (size == 3'b000) ? 1 : (size == 3'b001) ? 2 : 4;
    exp_rd  = '0;
    for (int b = 0; b < nbytes; b++) exp_rd |= 32'(gbyte(addr + 32'(b))) << (8 * b);
    wb_addr_q.delete(); wb_line_q.delete(); rf_addr_q.delete();

    access(rw, size, addr, wd, rd, mis, mreq, cyc, ok);

    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL resp_timeout addr=%h got=%b want=1", addr, ok); end
    checks++; if (mis !== exp_mis) begin errors++; $display("FAIL misalign addr=%h got=%b want=%b", addr, mis, exp_mis); end
    checks++; if (mreq !== 1'b0) begin errors++; $display("FAIL mem_req_at_resp addr=%h got=%b want=0", addr, mreq); end
    checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL stall_cycles addr=%h got=%0d want=%0d", addr, cyc, exp_cyc); end
    if (rw == 1'b0 && !exp_mis) begin
      checks++; if (rd !== exp_rd) begin errors++; $display("FAIL load_data addr=%h size=%0d got=%h want=%h", addr, size, rd, exp_rd); end
    end
    checks++; if (wb_addr_q.size() !== int'(exp_wb)) begin errors++; $display("FAIL wb_count addr=%h got=%0d want=%0d", addr, wb_addr_q.size(), int'(exp_wb)); end
    if (exp_wb && wb_addr_q.size() == 1) begin
      checks++; if (wb_addr_q[0] !== victim) begin errors++; $display("FAIL wb_addr got=%h want=%h", wb_addr_q[0], victim); end
      checks++; if (wb_line_q[0] !== gline(victim)) begin errors++; $display("FAIL wb_line victim=%h differs from golden", victim); end
    end
    checks++; if (rf_addr_q.size() !== int'(!exp_mis && !exp_hit)) begin errors++; $display("FAIL rf_count addr=%h got=%0d want=%0d", addr, rf_addr_q.size(), int'(!exp_mis && !exp_hit)); end
    if (!exp_mis && !exp_hit && rf_addr_q.size() == 1) begin
      checks++; if (rf_addr_q[0] !== base) begin errors++; $display("FAIL rf_addr got=%h want=%h", rf_addr_q[0], base); end
    end

    if (!exp_mis) begin
      if (!exp_hit) begin
        m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_base[idx] = base;
      end
      if (rw == 1'b1) begin
        for (int b = 0; b < nbytes; b++) golden[addr + 32'(b)] = wd[8*b +: 8];
        m_dirty[idx] = 1'b1;
      end
    end
  endtask

  task automatic do_flush(input logic with_req, output int n_wb);
    logic [31:0] exp_q[$];
    logic got;
    for (int i = 0; i < NL; i++) if (m_valid[i] && m_dirty[i]) exp_q.push_back(m_base[i]);
    wb_addr_q.delete(); wb_line_q.delete(); rf_addr_q.delete();
    flush = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_rw = 1'b0; req_size = 3'b010; req_addr = 32'h0000_1044;
    end
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got=%b want=1", stall); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_priority resp_valid got=%b want=0", resp_valid); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk); #1;
      if (flush_done) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL flush_done_timeout got=%b want=1", got); end
    @(posedge clk); #1;
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_done_pulse got=%b want=0", flush_done); end
    @(negedge clk);
    n_wb = wb_addr_q.size();
    checks++; if (n_wb !== exp_q.size()) begin errors++; $display("FAIL flush_wb_count got=%0d want=%0d", n_wb, exp_q.size()); end
    for (int i = 0; i < n_wb && i < exp_q.size(); i++) begin
      checks++; if (wb_addr_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_wb_addr[%0d] got=%h want=%h", i, wb_addr_q[i], exp_q[i]); end
      checks++; if (wb_line_q[i] !== gline(exp_q[i])) begin errors++; $display("FAIL flush_wb_line[%0d] addr=%h differs from golden", i, exp_q[i]); end
    end
    checks++; if (rf_addr_q.size() !== 0) begin errors++; $display("FAIL flush_refills got=%0d want=0", rf_addr_q.size()); end
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({resp_valid, resp_misalign, stall, flush_done, mem_req, mem_rw} !== 6'b0 ||
        resp_rdata !== '0 || mem_addr !== '0 || mem_wline !== '0) begin
      errors++;
      $display("FAIL %s outputs got rv=%b mis=%b st=%b fd=%b mreq=%b rdata=%h maddr=%h want all 0",
               tag, resp_valid, resp_misalign, stall, flush_done, mem_req, resp_rdata, mem_addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_size = 3'b010; req_addr = 32'h0000_1041;
    @(negedge clk); #1;
    check_outputs_zero("reset_with_req");
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_outputs_zero("reset_idle");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%b want=0", stall); end
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    logic [31:0] rd;
    logic [31:0] w;
    w = 32'hDEAD_BEEF;
    for (int b = 0; b < 4; b++) begin
      backing[32'h0000_1040 + 32'(b)] = w[8*b +: 8];
      golden[32'h0000_1040 + 32'(b)]  = w[8*b +: 8];
    end
    lat = 2;
    model_access(1'b0, 3'b010, 32'h0000_1040, '0, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cold_read got=%h want=deadbeef", rd); end
  endtask

  task automatic test_store_hit();
    logic [31:0] rd;
    model_access(1'b1, 3'b000, 32'h0000_1042, 32'h0000_00AB, rd);
    model_access(1'b0, 3'b010, 32'h0000_1040, '0, rd);
    checks++; if (rd !== 32'hDEAB_BEEF) begin errors++; $display("FAIL store_then_load got=%h want=deabbeef", rd); end
    model_access(1'b0, 3'b001, 32'h0000_1042, '0, rd);
    checks++; if (rd !== 32'h0000_DEAB) begin errors++; $display("FAIL half_zero_ext got=%h want=0000deab", rd); end
  endtask

  task automatic test_evict();
    logic [31:0] rd;
    lat = 1;
    model_access(1'b0, 3'b010, 32'h0000_2040, '0, rd);
    checks++; if (wb_addr_q[0] !== 32'h0000_1040) begin errors++; $display("FAIL evict_wb_addr got=%h want=00001040", wb_addr_q[0]); end
    checks++; if (wb_line_q[0][31:0] !== 32'hDEAB_BEEF) begin errors++; $display("FAIL evict_wb_word0 got=%h want=deabbeef", wb_line_q[0][31:0]); end
    checks++; if (rf_addr_q[0] !== 32'h0000_2040) begin errors++; $display("FAIL evict_rf_addr got=%h want=00002040", rf_addr_q[0]); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    model_access(1'b0, 3'b001, 32'h0000_1041, '0, rd);
    model_access(1'b0, 3'b010, 32'h0000_1042, '0, rd);
    model_access(1'b1, 3'b111, 32'h0000_2041, 32'h1234_5678, rd);
    model_access(1'b0, 3'b010, 32'h0000_2040, '0, rd);
  endtask

  task automatic test_random();
    logic [31:0] rd, addr;
    for (int n = 0; n < 150; n++) begin
      lat  = int'($urandom_range(0, 3));
      addr = 32'h0001_0000 | ($urandom_range(1, 3) << 8) | ($urandom_range(0, 3) << 6) | $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      model_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, rd);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd;
    int n_wb;
    lat = 1;
    do_flush(1'b1, n_wb);
    model_access(1'b1, 3'b010, 32'h0000_1044, 32'hCAFE_0001, rd);
    model_access(1'b1, 3'b010, 32'h0000_10C4, 32'hCAFE_0003, rd);
    do_flush(1'b0, n_wb);
    checks++; if (n_wb !== 2) begin errors++; $display("FAIL flush_two_wb got=%0d want=2", n_wb); end
    checks++; if (wb_addr_q[0] !== 32'h0000_1040 || wb_addr_q[1] !== 32'h0000_10C0) begin
      errors++; $display("FAIL flush_order got=%h,%h want=00001040,000010c0", wb_addr_q[0], wb_addr_q[1]);
    end
    model_access(1'b0, 3'b010, 32'h0000_1044, '0, rd);
    checks++; if (rd !== 32'hCAFE_0001) begin errors++; $display("FAIL flush_readback got=%h want=cafe0001", rd); end
    model_access(1'b0, 3'b010, 32'h0000_10C4, '0, rd);
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd;
    logic seen;
    lat = 0;
    model_access(1'b0, 3'b010, 32'h0000_3080, '0, rd);
    mem_hold = 1'b1;
    req_valid = 1'b1; req_rw = 1'b0; req_size = 3'b010; req_addr = 32'h0000_3100;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_rw == 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL refill_req_timeout got=%b want=1", seen); end
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_refill");
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_hold = 1'b0;
    model_reset();
    model_access(1'b0, 3'b010, 32'h0000_3080, '0, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_read();
    test_store_hit();
    test_evict();
    test_misalign();
    test_random();
    test_flush();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
